// File: rtl/cd_tx_ram_if.sv
// Host/TX-engine bundle for the paged transmit frame buffer.
// The master side is the host and serializer; the slave side is the buffer.
interface cd_tx_ram_if #(parameter int P_WIDTH = 2);
    logic [7:0]       wr_byte;
    logic [7:0]       wr_addr;
    logic             wr_en;
    logic [7:0]       wr_len;
    logic             switch;
    logic             switch_fail;
    logic             wr_full;
    logic [7:0]       rd_byte;
    logic [7:0]       rd_addr;
    logic             rd_en;
    logic [7:0]       rd_len;
    logic             rd_done;
    logic             clear;
    logic             tx_pend;
    logic [P_WIDTH:0] pend_cnt;

    modport master (
        output wr_byte, wr_addr, wr_en, wr_len, switch, rd_addr, rd_en, rd_done, clear,
        input  switch_fail, wr_full, rd_byte, rd_len, tx_pend, pend_cnt
    );

    modport slave (
        input  wr_byte, wr_addr, wr_en, wr_len, switch, rd_addr, rd_en, rd_done, clear,
        output switch_fail, wr_full, rd_byte, rd_len, tx_pend, pend_cnt
    );
endinterface

// File: rtl/cd_tx_ram.sv
// Transmit frame buffer: host fills a page and commits it, the TX engine drains
// committed pages in FIFO order. Storage is a 1R1W RAM with registered read.
module cd_sdpram #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [1<<AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

module cd_tx_ram #(
    parameter int P_WIDTH = 2
) (
    input logic           clk,
    input logic           reset,
    cd_tx_ram_if.slave    bus
);
    localparam int NPAGE = 1 << P_WIDTH;
    localparam logic [P_WIDTH-1:0] SEL_ONE = P_WIDTH'(1);
    localparam logic [P_WIDTH:0]   CNT_ONE = (P_WIDTH+1)'(1);

    logic [P_WIDTH-1:0] wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [NPAGE-1:0]   dirty_q, dirty_d;
    logic               wr_cancel_q, wr_cancel_d;
    logic               switch_d_q, switch_d_d;
    logic               switch_fail_q, switch_fail_d;
    logic               wr_full_q, wr_full_d;
    logic               tx_pend_q, tx_pend_d;
    logic [P_WIDTH:0]   pend_cnt_q, pend_cnt_d;
    logic [7:0]         len_q [NPAGE];
    logic [7:0]         len_d [NPAGE];
    logic               we_q, we_d;
    logic [P_WIDTH-1:0] wpage_q, wpage_d;
    logic [7:0]         waddr_q, waddr_d, wdata_q, wdata_d;

    logic wr_dirty, rd_dirty, commit_ok, commit_fail, rel;

    always_comb begin
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        dirty_d       = dirty_q;
        wr_cancel_d   = wr_cancel_q;
        pend_cnt_d    = pend_cnt_q;
        len_d         = len_q;

        wr_dirty    = dirty_q[wr_sel_q];
        rd_dirty    = dirty_q[rd_sel_q];
        commit_ok   = switch_d_q && !wr_cancel_q && !wr_dirty && !bus.clear;
        commit_fail = switch_d_q && (wr_cancel_q || wr_dirty);
        rel         = bus.rd_done && rd_dirty && !bus.clear;

        we_d          = bus.wr_en && !wr_cancel_q && !wr_dirty && !bus.clear;
        wpage_d       = wr_sel_q;
        waddr_d       = bus.wr_addr;
        wdata_d       = bus.wr_byte;
        switch_d_d    = bus.switch;
        switch_fail_d = commit_fail;

        // Once a byte is dropped the rest of the frame is dropped too, until the next commit attempt.
        if (bus.wr_en && wr_dirty) wr_cancel_d = 1'b1;
        if (switch_d_q)            wr_cancel_d = 1'b0;

        if (commit_ok) begin
            dirty_d[wr_sel_q] = 1'b1;
            len_d[wr_sel_q]   = bus.wr_len;
            wr_sel_d          = wr_sel_q + SEL_ONE;
        end
        if (rel) begin
            dirty_d[rd_sel_q] = 1'b0;
            rd_sel_d          = rd_sel_q + SEL_ONE;
        end

        if (commit_ok && !rel)      pend_cnt_d = pend_cnt_q + CNT_ONE;
        else if (!commit_ok && rel) pend_cnt_d = pend_cnt_q - CNT_ONE;

        // Suppress tx_pend for the cycle after a release so the engine sees a clean edge per page.
        tx_pend_d = rd_dirty && !rel;
        wr_full_d = wr_dirty;

        if (bus.clear) begin
            wr_sel_d      = '0;
            rd_sel_d      = '0;
            dirty_d       = '0;
            wr_cancel_d   = 1'b0;
            switch_d_d    = 1'b0;
            switch_fail_d = 1'b0;
            pend_cnt_d    = '0;
            tx_pend_d     = 1'b0;
            wr_full_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_sel_q      <= '0;
            rd_sel_q      <= '0;
            dirty_q       <= '0;
            wr_cancel_q   <= 1'b0;
            switch_d_q    <= 1'b0;
            switch_fail_q <= 1'b0;
            wr_full_q     <= 1'b0;
            tx_pend_q     <= 1'b0;
            pend_cnt_q    <= '0;
            we_q          <= 1'b0;
            wpage_q       <= '0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            for (int i = 0; i < NPAGE; i++) len_q[i] <= '0;
        end else begin
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            dirty_q       <= dirty_d;
            wr_cancel_q   <= wr_cancel_d;
            switch_d_q    <= switch_d_d;
            switch_fail_q <= switch_fail_d;
            wr_full_q     <= wr_full_d;
            tx_pend_q     <= tx_pend_d;
            pend_cnt_q    <= pend_cnt_d;
            we_q          <= we_d;
            wpage_q       <= wpage_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            len_q         <= len_d;
        end
    end

    cd_sdpram #(.AW(P_WIDTH + 8), .DW(8)) u_ram (
        .clk     (clk),
        .rst     (reset),
        .we_i    (we_q),
        .waddr_i ({wpage_q, waddr_q}),
        .wdata_i (wdata_q),
        .re_i    (bus.rd_en),
        .raddr_i ({rd_sel_q, bus.rd_addr}),
        .rdata_o (bus.rd_byte)
    );

    assign bus.switch_fail = switch_fail_q;
    assign bus.wr_full     = wr_full_q;
    assign bus.tx_pend     = tx_pend_q;
    assign bus.pend_cnt    = pend_cnt_q;
    assign bus.rd_len      = len_q[rd_sel_q];
endmodule
